// File: rtl/io_pkg.sv
// Shared types and constants for the CPU IO access controller.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } io_state_e;

    localparam int unsigned PERIPH_NUM     = 4;
    localparam logic [7:0]  TIMEOUT_CYCLES = 8'd255;

    // Field positions within addr_low
    localparam int unsigned PAGE_MSB  = 9;
    localparam int unsigned PAGE_LSB  = 6;
    localparam int unsigned IDX_MSB   = 5;
    localparam int unsigned IDX_LSB   = 4;
    localparam int unsigned REG_MSB   = 3;
    localparam int unsigned REG_LSB   = 2;
    localparam int unsigned ALIGN_MSB = 1;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED   = 2'b01;
    localparam logic [1:0] ERR_MISALIGNED = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

    function automatic logic [PERIPH_NUM-1:0] idx_to_sel(input logic [1:0] idx);
        logic [PERIPH_NUM-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/io_addr_decode.sv
// Splits the low IO address bits into peripheral index, register offset and
// mapped / misaligned flags.
module io_addr_decode
    import io_pkg::*;
(
    input  logic [9:0] addr_low_i,
    output logic [1:0] index_o,
    output logic [1:0] reg_o,
    output logic       mapped_o,
    output logic       misaligned_o
);

    assign index_o      = addr_low_i[IDX_MSB:IDX_LSB];
    assign reg_o        = addr_low_i[REG_MSB:REG_LSB];
    assign mapped_o     = (addr_low_i[PAGE_MSB:PAGE_LSB] == 4'd0);
    assign misaligned_o = (addr_low_i[ALIGN_MSB:0] != 2'd0);

endmodule

// File: rtl/io_access_ctrl.sv
// Sequences one CPU IO load/store onto a four-slot peripheral bus, stalling the
// CPU until the peripheral acks, times out, or the address is rejected.
module io_access_ctrl
    import io_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         io_read,
    input  logic         io_write,
    input  logic [9:0]   addr_low,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic         stall,
    output logic         per_req,
    output logic [3:0]   per_sel,
    output logic         per_we,
    output logic [1:0]   per_reg,
    output logic [31:0]  per_wdata,
    input  logic [3:0]   per_ack,
    input  logic [127:0] per_rdata,
    output logic [1:0]   err_code,
    input  logic         err_clr
);

    io_state_e   state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  reg_q, reg_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic [1:0]  new_err;

    logic [1:0]  dec_idx;
    logic [1:0]  dec_reg;
    logic        dec_mapped;
    logic        dec_misaligned;

    io_addr_decode u_decode (
        .addr_low_i   (addr_low),
        .index_o      (dec_idx),
        .reg_o        (dec_reg),
        .mapped_o     (dec_mapped),
        .misaligned_o (dec_misaligned)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        reg_d   = reg_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        new_err = ERR_NONE;

        unique case (state_q)
            IDLE: begin
                if (io_read && io_write) begin
                    new_err = ERR_UNMAPPED;
                    state_d = DONE;
                end else if (io_read || io_write) begin
                    if (!dec_mapped) begin
                        new_err = ERR_UNMAPPED;
                        state_d = DONE;
                    end else if (dec_misaligned) begin
                        new_err = ERR_MISALIGNED;
                        state_d = DONE;
                    end else begin
                        idx_d   = dec_idx;
                        reg_d   = dec_reg;
                        we_d    = io_write;
                        wdata_d = wdata;
                        cnt_d   = 8'd0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (per_ack[idx_q]) begin
                    if (!we_q) begin
                        rdata_d = per_rdata[{idx_q, 5'd0} +: 32];
                    end
                    state_d = DONE;
                end else if (cnt_d == TIMEOUT_CYCLES) begin
                    new_err = ERR_TIMEOUT;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear and a fresh error in the same cycle leave the fresh error recorded
        err_d = err_clr ? ERR_NONE : err_q;
        if ((new_err != ERR_NONE) && (err_d == ERR_NONE)) begin
            err_d = new_err;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            reg_q   <= 2'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            reg_q   <= reg_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign per_req   = (state_q == REQ);
    assign per_sel   = per_req ? idx_to_sel(idx_q) : 4'd0;
    assign per_we    = we_q;
    assign per_reg   = reg_q;
    assign per_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign err_code  = err_q;
    assign stall     = (io_read || io_write) && (state_q != DONE);

endmodule

// File: tb/tb_io_access_ctrl.sv
// Directed bench for io_access_ctrl: reads, writes, address errors, timeout,
// error clearing and reset in the middle of an access.
module tb_io_access_ctrl;

    logic         clock;
    logic         reset;
    logic         io_read;
    logic         io_write;
    logic [9:0]   addr_low;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         stall;
    logic         per_req;
    logic [3:0]   per_sel;
    logic         per_we;
    logic [1:0]   per_reg;
    logic [31:0]  per_wdata;
    logic [3:0]   per_ack;
    logic [127:0] per_rdata;
    logic [1:0]   err_code;
    logic         err_clr;

    int errors = 0;
    int checks = 0;

    io_access_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .io_read   (io_read),
        .io_write  (io_write),
        .addr_low  (addr_low),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .per_req   (per_req),
        .per_sel   (per_sel),
        .per_we    (per_we),
        .per_reg   (per_reg),
        .per_wdata (per_wdata),
        .per_ack   (per_ack),
        .per_rdata (per_rdata),
        .err_code  (err_code),
        .err_clr   (err_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        io_read   = 1'b0;
        io_write  = 1'b0;
        addr_low  = 10'd0;
        wdata     = 32'd0;
        per_ack   = 4'd0;
        per_rdata = {32'hDDDD0003, 32'hCCCC0002, 32'h12345678, 32'hAAAA0000};
        err_clr   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {30'd0, err_code}, 32'd0);
        check("rst_req", {31'd0, per_req}, 32'd0);
        check("rst_sel", {28'd0, per_sel}, 32'd0);
        check("rst_we", {31'd0, per_we}, 32'd0);
        check("rst_reg", {30'd0, per_reg}, 32'd0);
        check("rst_wdata", per_wdata, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        tick();

        // Minimum-latency read of peripheral 1, register 1
        io_read  = 1'b1;
        addr_low = 10'h014;
        #1;
        check("rd_c0_stall", {31'd0, stall}, 32'd1);
        check("rd_c0_req", {31'd0, per_req}, 32'd0);
        tick();
        check("rd_c1_stall", {31'd0, stall}, 32'd1);
        check("rd_c1_req", {31'd0, per_req}, 32'd1);
        check("rd_c1_sel", {28'd0, per_sel}, 32'h2);
        check("rd_c1_we", {31'd0, per_we}, 32'd0);
        check("rd_c1_reg", {30'd0, per_reg}, 32'd1);
        per_ack = 4'b0010;
        tick();
        check("rd_c2_stall", {31'd0, stall}, 32'd0);
        check("rd_c2_rdata", rdata, 32'h12345678);
        check("rd_c2_req", {31'd0, per_req}, 32'd0);
        check("rd_c2_sel", {28'd0, per_sel}, 32'd0);
        io_read = 1'b0;
        per_ack = 4'd0;
        tick();

        // Write to peripheral 3, register 3, acked on the third REQ cycle
        io_write = 1'b1;
        addr_low = 10'h03C;
        wdata    = 32'hA5A5A5A5;
        #1;
        check("wr_c0_stall", {31'd0, stall}, 32'd1);
        tick();
        wdata = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            per_ack = (i == 3) ? 4'b1000 : 4'b0111;
            #1;
            check($sformatf("wr_c%0d_stall", i), {31'd0, stall}, 32'd1);
            check($sformatf("wr_c%0d_req", i), {31'd0, per_req}, 32'd1);
            check($sformatf("wr_c%0d_sel", i), {28'd0, per_sel}, 32'h8);
            check($sformatf("wr_c%0d_we", i), {31'd0, per_we}, 32'd1);
            check($sformatf("wr_c%0d_reg", i), {30'd0, per_reg}, 32'd3);
            check($sformatf("wr_c%0d_wdata", i), per_wdata, 32'hA5A5A5A5);
            tick();
        end
        check("wr_c4_stall", {31'd0, stall}, 32'd0);
        check("wr_c4_req", {31'd0, per_req}, 32'd0);
        check("wr_rdata_kept", rdata, 32'h12345678);
        check("wr_err", {30'd0, err_code}, 32'd0);
        io_write = 1'b0;
        per_ack  = 4'd0;
        tick();

        // Unmapped read, then a misaligned read issued right after DONE
        io_read  = 1'b1;
        addr_low = 10'h100;
        #1;
        check("um_c0_stall", {31'd0, stall}, 32'd1);
        check("um_c0_req", {31'd0, per_req}, 32'd0);
        tick();
        check("um_done_err", {30'd0, err_code}, 32'd1);
        check("um_done_stall", {31'd0, stall}, 32'd0);
        check("um_done_req", {31'd0, per_req}, 32'd0);
        addr_low = 10'h006;
        tick();
        check("ma_c0_stall", {31'd0, stall}, 32'd1);
        check("ma_c0_req", {31'd0, per_req}, 32'd0);
        tick();
        check("ma_done_stall", {31'd0, stall}, 32'd0);
        check("ma_sticky_err", {30'd0, err_code}, 32'd1);
        io_read = 1'b0;
        err_clr = 1'b1;
        tick();
        check("clr_err", {30'd0, err_code}, 32'd0);

        // Misaligned error in the same cycle as err_clr is still recorded
        io_read  = 1'b1;
        addr_low = 10'h006;
        tick();
        err_clr = 1'b0;
        check("clr_same_cycle_err", {30'd0, err_code}, 32'd2);
        io_read = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err2", {30'd0, err_code}, 32'd0);

        // Simultaneous read and write counts as unmapped
        io_read  = 1'b1;
        io_write = 1'b1;
        addr_low = 10'h010;
        tick();
        check("rw_both_err", {30'd0, err_code}, 32'd1);
        check("rw_both_req", {31'd0, per_req}, 32'd0);
        check("rw_both_rdata", rdata, 32'h12345678);
        io_read  = 1'b0;
        io_write = 1'b0;
        err_clr  = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err3", {30'd0, err_code}, 32'd0);

        // Read of peripheral 0 with no ack from it: times out after 255 REQ cycles
        io_read  = 1'b1;
        addr_low = 10'h000;
        per_ack  = 4'b1110;
        tick();
        for (int i = 1; i <= 255; i++) begin
            if (per_req !== 1'b1 || stall !== 1'b1) begin
                check($sformatf("to_req_c%0d", i), {30'd0, per_req, stall}, 32'd3);
            end
            if (i < 255) tick();
        end
        check("to_last_req", {31'd0, per_req}, 32'd1);
        check("to_last_err", {30'd0, err_code}, 32'd0);
        tick();
        check("to_done_err", {30'd0, err_code}, 32'd3);
        check("to_done_rdata", rdata, 32'd0);
        check("to_done_stall", {31'd0, stall}, 32'd0);
        io_read = 1'b0;
        per_ack = 4'd0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_clr_err", {30'd0, err_code}, 32'd0);

        // Reset on the second REQ cycle, with an ack arriving at the same time
        io_read  = 1'b1;
        addr_low = 10'h000;
        tick();
        check("rr_c1_req", {31'd0, per_req}, 32'd1);
        tick();
        check("rr_c2_req", {31'd0, per_req}, 32'd1);
        reset   = 1'b1;
        per_ack = 4'b0001;
        tick();
        reset = 1'b0;
        check("rr_req_dropped", {31'd0, per_req}, 32'd0);
        check("rr_sel_dropped", {28'd0, per_sel}, 32'd0);
        check("rr_idle_stall", {31'd0, stall}, 32'd1);
        check("rr_rdata", rdata, 32'd0);
        io_read = 1'b0;
        tick();
        tick();
        check("rr_late_ack_req", {31'd0, per_req}, 32'd0);
        check("rr_late_ack_rdata", rdata, 32'd0);
        check("rr_err", {30'd0, err_code}, 32'd0);
        per_ack = 4'd0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
